seq_restoring_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider: the inverse operation to the Booth shift-add multiplier.

---
 rtl/seq_restoring_divider_if.sv | 34 +++
 rtl/seq_restoring_divider.sv | 158 +++++++++++++++
 tb/tb_seq_restoring_divider.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider_if
// Description : Start/done handshake and operand/result bundle for the
//               sequential restoring divider.
//               master : drives start, dividend, divisor; observes results
//               slave  : the divider itself
//               Signals: start, dividend[N], divisor[N] (request side)
//                        quotient[N], remainder[N], busy, done, div_by_zero
// Revision    : 1.0  initial release
// ============================================================================
interface seq_restoring_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider
// Description : Multi-cycle unsigned restoring divider. One quotient bit per
//               iteration: shift {A,Q} left, subtract M, restore if negative.
// Ports       : clk   - rising-edge clock
//               rstn  - asynchronous active-low reset
//               bus   - seq_restoring_divider_if.slave
//                       start/dividend/divisor in; quotient/remainder,
//                       busy, done (1-cycle pulse), div_by_zero out
// Revision    : 1.0  initial release
// ============================================================================
module seq_restoring_divider #(
    parameter int N = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rstn,
    seq_restoring_divider_if.slave    bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_SUB     = 3'd2,
        ST_RESTORE = 3'd3,
        ST_ZERO    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t          r_state, w_state_next;
    logic [N:0]      r_a, w_a_next;          // signed partial remainder
    logic [N-1:0]    r_q, w_q_next;          // dividend shifting into quotient
    logic [N-1:0]    r_m, w_m_next;          // divisor
    logic [CW-1:0]   r_cnt, w_cnt_next;      // quotient bits still to produce
    logic [N-1:0]    r_quotient, w_quotient_next;
    logic [N-1:0]    r_remainder, w_remainder_next;
    logic            r_div_by_zero, w_div_by_zero_next;
    logic [N:0]      w_diff;
    logic [N:0]      w_sum;

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_a_next           = r_a;
        w_q_next           = r_q;
        w_m_next           = r_m;
        w_cnt_next         = r_cnt;
        w_quotient_next    = r_quotient;
        w_remainder_next   = r_remainder;
        w_div_by_zero_next = r_div_by_zero;
        w_diff             = r_a - {1'b0, r_m};
        w_sum              = r_a + {1'b0, r_m};

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_div_by_zero_next = 1'b0;
                    w_a_next           = '0;
                    w_q_next           = bus.dividend;
                    w_m_next           = bus.divisor;
                    w_cnt_next         = CW'(N);
                    // A zero divisor skips the iteration loop but still
                    // takes one cycle so its done lands one edge after
                    // acceptance, together with the flag and results.
                    if (bus.divisor == '0) begin
                        w_state_next = ST_ZERO;
                    end else begin
                        w_state_next = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                // A[N] is always 0 here (A < M after every step), so it
                // is dropped by the shift.
                {w_a_next, w_q_next} = {r_a[N-1:0], r_q, 1'b0};
                w_state_next         = ST_SUB;
            end

            ST_SUB: begin
                w_a_next = w_diff;
                if (w_diff[N]) begin
                    w_state_next = ST_RESTORE;
                end else begin
                    w_q_next     = {r_q[N-1:1], 1'b1};
                    w_cnt_next   = r_cnt - CW'(1);
                    w_state_next = (r_cnt == CW'(1)) ? ST_DONE : ST_SHIFT;
                end
            end

            ST_RESTORE: begin
                w_a_next     = w_sum;
                w_q_next     = {r_q[N-1:1], 1'b0};
                w_cnt_next   = r_cnt - CW'(1);
                w_state_next = (r_cnt == CW'(1)) ? ST_DONE : ST_SHIFT;
            end

            ST_ZERO: begin
                w_quotient_next    = '1;
                w_remainder_next   = r_q;
                w_div_by_zero_next = 1'b1;
                w_state_next       = ST_DONE;
            end

            ST_DONE: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Results are published on the edge that enters ST_DONE so they
        // are already valid during the done pulse.
        if ((w_state_next == ST_DONE) &&
            ((r_state == ST_SUB) || (r_state == ST_RESTORE))) begin
            w_quotient_next  = w_q_next;
            w_remainder_next = w_a_next[N-1:0];
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_a           <= '0;
            r_q           <= '0;
            r_m           <= '0;
            r_cnt         <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_a           <= w_a_next;
            r_q           <= w_q_next;
            r_m           <= w_m_next;
            r_cnt         <= w_cnt_next;
            r_quotient    <= w_quotient_next;
            r_remainder   <= w_remainder_next;
            r_div_by_zero <= w_div_by_zero_next;
        end
    end

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_restoring_divider
// Description : Self-checking bench for seq_restoring_divider (N=8): vector
//               table, handshake/reset corner sequences, randomized operands
//               against a plain-arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_restoring_divider;
    localparam int N = 8;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_err;

    seq_restoring_divider_if #(.N(N)) bus ();

    seq_restoring_divider #(.N(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: plain division; latency = 2N + number of zero quotient bits.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic [N-1:0] r,
                         output logic dbz, output int lat);
        if (b == 0) begin
            q   = '1;
            r   = a;
            dbz = 1'b1;
            lat = 1;
        end else begin
            q   = a / b;
            r   = a % b;
            dbz = 1'b0;
            lat = 2 * N + (N - $countones(q));
        end
    endtask

    // Waits for done, counting cycles from the current sample point.
    task automatic wait_done(input int max, output int lat, output bit seen, output bit busy_ok);
        lat     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && lat < max) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er,
                          input logic edbz, input int elat);
        int lat;
        bit seen, busy_ok;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = N'($urandom);
        bus.divisor  = N'($urandom);
        chk({tag, " busy_at_E0"}, 32'(bus.busy), 32'd1);
        wait_done(elat + 8, lat, seen, busy_ok);
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " busy_until_done"}, 32'(busy_ok), 32'd1);
        chk({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(bus.remainder), 32'(er));
        chk({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(edbz));
        @(posedge clk); #1;
        chk({tag, " done_pulse_end"}, 32'(bus.done), 32'd0);
        chk({tag, " idle_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        bit seen, busy_ok, no_done;
        logic [N-1:0] ma, mb, mq, mr;
        logic mdbz;
        int mlat;

        n_vec = 0;
        n_err = 0;
        rstn         = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 21};
        tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 16};
        tbl[2] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 23};
        tbl[3] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 24};
        tbl[4] = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 24};
        tbl[5] = '{8'd77,  8'd0,   8'd255, 8'd77, 1'b1, 1};
        tbl[6] = '{8'd77,  8'd7,   8'd11,  8'd0,  1'b0, 21};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset quotient", 32'(bus.quotient), 32'd0);
        chk("reset remainder", 32'(bus.remainder), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("tbl%0d_%0d/%0d", i, tbl[i].a, tbl[i].b),
                   tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].lat);
        end

        // start pulsed mid-operation is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(40, lat, seen, busy_ok);
        chk("ignore done_seen", 32'(seen), 32'd1);
        chk("ignore latency", 32'(lat + 6), 32'd21);
        chk("ignore quotient", 32'(bus.quotient), 32'd14);
        chk("ignore remainder", 32'(bus.remainder), 32'd2);

        // start held through done: re-accepted after a one-cycle idle gap
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
        @(posedge clk); #1;
        chk("hold idle_gap", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        chk("hold accepted", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done(40, lat, seen, busy_ok);
        chk("hold done_seen", 32'(seen), 32'd1);
        chk("hold latency", 32'(lat), 32'd22);
        chk("hold quotient", 32'(bus.quotient), 32'd66);
        chk("hold remainder", 32'(bus.remainder), 32'd2);
        @(posedge clk); #1;

        // Reset mid-operation
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("midreset quotient", 32'(bus.quotient), 32'd0);
        chk("midreset remainder", 32'(bus.remainder), 32'd0);
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset done", 32'(bus.done), 32'd0);
        chk("midreset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        no_done = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) no_done = 1'b0;
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) no_done = 1'b0;
        end
        chk("midreset no_done", 32'(no_done), 32'd1);
        run_op("after_reset_9/4", 8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 23);

        // Randomized operands against the reference model
        for (int i = 0; i < 1500; i++) begin
            ma = N'($urandom);
            case ($urandom_range(0, 9))
                0:       mb = '0;
                1, 2:    mb = N'($urandom_range(1, 15));
                default: mb = N'($urandom_range(1, 255));
            endcase
            model(ma, mb, mq, mr, mdbz, mlat);
            run_op($sformatf("rnd%0d_%0d/%0d", i, ma, mb), ma, mb, mq, mr, mdbz, mlat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
